// File: rtl/memory_arbiter.sv
// Shared-RAM arbiter: serves one instruction-fetch or data access at a time,
// with data priority, a one-shot fairness rule for instruction fetch after a
// data access, and a watchdog that aborts an access when the RAM never answers.
// Latency: request seen at edge 0, strobe in cycle 1, ram_ready at edge k,
// hit in cycle k+1 (2 cycles minimum).
// Backpressure: requesters hold their request until hit; a request dropped
// before ram_ready abandons the access silently.
//
// Ports:
//   CLK, nRST            clock, synchronous active-low reset
//   iREN, iaddr          instruction read request / address
//   dREN, dWEN, daddr,   data read / write request, address, write value
//   dstore
//   ram_ready, ram_load  RAM completion flag and read data
//   ramREN, ramWEN,      RAM strobes, address and write data
//   ramaddr, ramstore
//   ihit, iload          one-cycle instruction completion and fetched word
//   dhit, dload          one-cycle data completion and read word (0 on writes)
//   mem_err              one-cycle pulse when the watchdog aborts an access
module memory_arbiter #(
   parameter int TIMEOUT = 64,
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              iREN,
   input  logic [ADDR_W-1:0] iaddr,
   input  logic              dREN,
   input  logic              dWEN,
   input  logic [ADDR_W-1:0] daddr,
   input  logic [DATA_W-1:0] dstore,
   input  logic              ram_ready,
   input  logic [DATA_W-1:0] ram_load,
   output logic              ramREN,
   output logic              ramWEN,
   output logic [ADDR_W-1:0] ramaddr,
   output logic [DATA_W-1:0] ramstore,
   output logic              ihit,
   output logic [DATA_W-1:0] iload,
   output logic              dhit,
   output logic [DATA_W-1:0] dload,
   output logic              mem_err
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DREQ = 2'd1,
      IREQ = 2'd2,
      RESP = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              ifirst_q, ifirst_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] store_q, store_d;
   logic              wr_q, wr_d;
   logic              isd_q, isd_d;      // current/last transaction belongs to the data port
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              err_q, err_d;

   logic              ramREN_q, ramWEN_q, ihit_q, dhit_q, mem_err_q;
   logic [ADDR_W-1:0] ramaddr_q;
   logic [DATA_W-1:0] ramstore_q, iload_q, dload_q;

   logic own_req;
   logic in_req_d;
   logic resp_ok_d;

   // Request that owns the in-flight access; dropping it abandons the access.
   assign own_req = isd_q ? (dREN | dWEN) : iREN;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      ifirst_d = ifirst_q;
      addr_d   = addr_q;
      store_d  = store_q;
      wr_d     = wr_q;
      isd_d    = isd_q;
      rdata_d  = rdata_q;
      err_d    = err_q;
      case (state_q)
         IDLE: begin
            err_d = 1'b0;
            // Data wins unless the fairness flag hands this slot to a pending fetch.
            if ((dREN | dWEN) && !(ifirst_q && iREN)) begin
               state_d = DREQ;
               addr_d  = daddr;
               store_d = dstore;
               wr_d    = dWEN;
               isd_d   = 1'b1;
               cnt_d   = '0;
            end else if (iREN) begin
               state_d  = IREQ;
               addr_d   = iaddr;
               wr_d     = 1'b0;
               isd_d    = 1'b0;
               ifirst_d = 1'b0;
               cnt_d    = '0;
            end
         end
         DREQ, IREQ: begin
            if (ram_ready) begin
               state_d = RESP;
               rdata_d = wr_q ? '0 : ram_load;
               err_d   = 1'b0;
               cnt_d   = '0;
               if (state_q == DREQ) ifirst_d = 1'b1;
            end else if (!own_req) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_MAX) begin
               state_d = RESP;
               rdata_d = '0;
               err_d   = 1'b1;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RESP: begin
            // Inputs ignored so a still-held request is not accepted twice.
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign in_req_d  = (state_d == DREQ) || (state_d == IREQ);
   assign resp_ok_d = (state_d == RESP) && !err_d;

   // Outputs are registered from the next state so they line up with state_q.
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         ifirst_q   <= 1'b0;
         addr_q     <= '0;
         store_q    <= '0;
         wr_q       <= 1'b0;
         isd_q      <= 1'b0;
         rdata_q    <= '0;
         err_q      <= 1'b0;
         ramREN_q   <= 1'b0;
         ramWEN_q   <= 1'b0;
         ramaddr_q  <= '0;
         ramstore_q <= '0;
         ihit_q     <= 1'b0;
         iload_q    <= '0;
         dhit_q     <= 1'b0;
         dload_q    <= '0;
         mem_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         ifirst_q   <= ifirst_d;
         addr_q     <= addr_d;
         store_q    <= store_d;
         wr_q       <= wr_d;
         isd_q      <= isd_d;
         rdata_q    <= rdata_d;
         err_q      <= err_d;
         ramREN_q   <= in_req_d && !wr_d;
         ramWEN_q   <= (state_d == DREQ) && wr_d;
         ramaddr_q  <= in_req_d ? addr_d : '0;
         ramstore_q <= (state_d == DREQ) ? store_d : '0;
         ihit_q     <= resp_ok_d && !isd_d;
         iload_q    <= (resp_ok_d && !isd_d) ? rdata_d : '0;
         dhit_q     <= resp_ok_d && isd_d;
         dload_q    <= (resp_ok_d && isd_d) ? rdata_d : '0;
         mem_err_q  <= (state_d == RESP) && err_d;
      end
   end

   assign ramREN   = ramREN_q;
   assign ramWEN   = ramWEN_q;
   assign ramaddr  = ramaddr_q;
   assign ramstore = ramstore_q;
   assign ihit     = ihit_q;
   assign iload    = iload_q;
   assign dhit     = dhit_q;
   assign dload    = dload_q;
   assign mem_err  = mem_err_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter with TIMEOUT=4: reset, fetch, priority
// and fairness, withdrawal, watchdog abort and reset mid-transaction.
module tb_memory_arbiter;

   logic        CLK = 1'b0;
   logic        nRST;
   logic        iREN;
   logic [31:0] iaddr;
   logic        dREN;
   logic        dWEN;
   logic [31:0] daddr;
   logic [31:0] dstore;
   logic        ram_ready;
   logic [31:0] ram_load;
   logic        ramREN;
   logic        ramWEN;
   logic [31:0] ramaddr;
   logic [31:0] ramstore;
   logic        ihit;
   logic [31:0] iload;
   logic        dhit;
   logic [31:0] dload;
   logic        mem_err;

   int n_chk  = 0;
   int n_pass = 0;

   memory_arbiter #(.TIMEOUT(4), .ADDR_W(32), .DATA_W(32)) dut (
      .CLK(CLK), .nRST(nRST),
      .iREN(iREN), .iaddr(iaddr),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
      .ram_ready(ram_ready), .ram_load(ram_load),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
      .ihit(ihit), .iload(iload), .dhit(dhit), .dload(dload), .mem_err(mem_err)
   );

   always #5 CLK = ~CLK;

   // Advance one edge and settle 1 time unit past it.
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, ".ramREN"},   {31'd0, ramREN},  32'd0);
      chk({tag, ".ramWEN"},   {31'd0, ramWEN},  32'd0);
      chk({tag, ".ramaddr"},  ramaddr,          32'd0);
      chk({tag, ".ramstore"}, ramstore,         32'd0);
      chk({tag, ".ihit"},     {31'd0, ihit},    32'd0);
      chk({tag, ".iload"},    iload,            32'd0);
      chk({tag, ".dhit"},     {31'd0, dhit},    32'd0);
      chk({tag, ".dload"},    dload,            32'd0);
      chk({tag, ".mem_err"},  {31'd0, mem_err}, 32'd0);
   endtask

   initial begin
      nRST = 1'b0; iREN = 1'b1; iaddr = 32'h300; dREN = 1'b1; dWEN = 1'b0;
      daddr = 32'h200; dstore = 32'h0; ram_ready = 1'b0; ram_load = 32'h0;

      // Reset held two edges with both requests pending.
      step(); step();
      chk_quiet("rst");

      // Release: data wins, first strobe is a read of daddr.
      nRST = 1'b1;
      step();
      chk("rel.ramREN",  {31'd0, ramREN}, 32'd1);
      chk("rel.ramWEN",  {31'd0, ramWEN}, 32'd0);
      chk("rel.ramaddr", ramaddr,         32'h200);
      iREN = 1'b0; dREN = 1'b0;
      step();
      chk_quiet("rel.drop");
      step();

      // Instruction fetch, ram_ready after 3 strobe cycles.
      iREN = 1'b1; iaddr = 32'h0000_0040;
      step();
      chk("if.c1.ramREN",  {31'd0, ramREN}, 32'd1);
      chk("if.c1.ramaddr", ramaddr,         32'h40);
      step();
      chk("if.c2.ramREN",  {31'd0, ramREN}, 32'd1);
      step();
      chk("if.c3.ramREN",  {31'd0, ramREN}, 32'd1);
      chk("if.c3.ihit",    {31'd0, ihit},   32'd0);
      ram_ready = 1'b1; ram_load = 32'h2001_0005;
      step();
      chk("if.ihit",   {31'd0, ihit},   32'd1);
      chk("if.iload",  iload,           32'h2001_0005);
      chk("if.dhit",   {31'd0, dhit},   32'd0);
      chk("if.ramREN", {31'd0, ramREN}, 32'd0);
      ram_ready = 1'b0; ram_load = 32'h0;
      step();
      chk_quiet("if.after");
      iREN = 1'b0;
      step();
      chk_quiet("if.idle");

      // Simultaneous write and fetch: data first, then fairness forces the fetch.
      iREN = 1'b1; iaddr = 32'h80; dWEN = 1'b1; daddr = 32'h100; dstore = 32'hDEAD_BEEF;
      step();
      chk("sim.ramWEN",   {31'd0, ramWEN}, 32'd1);
      chk("sim.ramREN",   {31'd0, ramREN}, 32'd0);
      chk("sim.ramaddr",  ramaddr,         32'h100);
      chk("sim.ramstore", ramstore,        32'hDEAD_BEEF);
      ram_ready = 1'b1; ram_load = 32'h1234_5678;
      step();
      chk("sim.dhit",  {31'd0, dhit}, 32'd1);
      chk("sim.dload", dload,         32'h0);
      chk("sim.ihit",  {31'd0, ihit}, 32'd0);
      ram_ready = 1'b0; ram_load = 32'h0;
      step();
      chk_quiet("sim.resp_out");
      step();
      chk("fair.ramREN",   {31'd0, ramREN}, 32'd1);
      chk("fair.ramWEN",   {31'd0, ramWEN}, 32'd0);
      chk("fair.ramaddr",  ramaddr,         32'h80);
      chk("fair.ramstore", ramstore,        32'h0);
      ram_ready = 1'b1; ram_load = 32'hCAFE_0001;
      step();
      chk("fair.ihit",  {31'd0, ihit}, 32'd1);
      chk("fair.iload", iload,         32'hCAFE_0001);
      chk("fair.dhit",  {31'd0, dhit}, 32'd0);
      ram_ready = 1'b0; ram_load = 32'h0; iREN = 1'b0; dWEN = 1'b0;
      step();
      chk_quiet("fair.after");

      // Withdrawal of a data read before ram_ready.
      dREN = 1'b1; daddr = 32'h300;
      step();
      chk("wd.c1.ramREN",  {31'd0, ramREN}, 32'd1);
      chk("wd.c1.ramaddr", ramaddr,         32'h300);
      step();
      chk("wd.c2.ramREN",  {31'd0, ramREN}, 32'd1);
      dREN = 1'b0;
      step();
      chk_quiet("wd.drop");
      step();
      chk_quiet("wd.later");

      // Watchdog: strobe for exactly 4 cycles, then a lone mem_err.
      iREN = 1'b1; iaddr = 32'h44;
      for (int c = 1; c <= 4; c++) begin
         step();
         chk($sformatf("wdog.c%0d.ramREN", c), {31'd0, ramREN}, 32'd1);
         chk($sformatf("wdog.c%0d.mem_err", c), {31'd0, mem_err}, 32'd0);
      end
      step();
      chk("wdog.mem_err", {31'd0, mem_err}, 32'd1);
      chk("wdog.ihit",    {31'd0, ihit},    32'd0);
      chk("wdog.ramREN",  {31'd0, ramREN},  32'd0);
      step();
      chk_quiet("wdog.idle");
      step();
      chk("wdog.rearb.ramREN",  {31'd0, ramREN}, 32'd1);
      chk("wdog.rearb.ramaddr", ramaddr,         32'h44);
      iREN = 1'b0;
      step();
      chk_quiet("wdog.drop");

      // Reset while a data access is outstanding.
      dREN = 1'b1; daddr = 32'h500;
      step();
      chk("mrst.ramREN",  {31'd0, ramREN}, 32'd1);
      chk("mrst.ramaddr", ramaddr,         32'h500);
      nRST = 1'b0;
      step();
      chk_quiet("mrst.rst");
      nRST = 1'b1; dREN = 1'b0; ram_ready = 1'b1; ram_load = 32'h5555_AAAA;
      for (int c = 0; c < 3; c++) begin
         step();
         chk_quiet($sformatf("mrst.post%0d", c));
      end
      ram_ready = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "bench timeout");
   end

endmodule

// File: doc/memory_arbiter.md
Name: memory_arbiter

Overview:
- Arbitrates the instruction-fetch and data-access ports onto the single shared RAM port.
- Produces the ihit/dhit pulses that the hazard unit consumes to generate pipeline-register enables and flushes. It is the stage directly upstream of the hazard unit.
- Serves one transaction at a time.
- Data has priority, with a one-shot fairness rule to prevent instruction starvation.
- A watchdog timer aborts transactions on a hung RAM.

Parameters:
- TIMEOUT, 64, max cycles to wait for ram_ready before aborting a transaction (must be >= 1).
- ADDR_W, 32, address width.
- DATA_W, 32, data word width.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- nRST  in  1  reset, synchronous, active-low.
- iREN  in  1  instruction read request; held until ihit or withdrawn.
- iaddr  in  ADDR_W  instruction address.
- dREN  in  1  data read request.
- dWEN  in  1  data write request; dREN and dWEN are never both 1.
- daddr  in  ADDR_W  data address.
- dstore  in  DATA_W  data write value.
- ram_ready  in  1  RAM has completed the current access.
- ram_load  in  DATA_W  RAM read data, valid when ram_ready=1.
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  ADDR_W  RAM address.
- ramstore  out  DATA_W  RAM write data.
- ihit  out  1  one-cycle instruction-complete pulse.
- iload  out  DATA_W  fetched instruction, valid with ihit.
- dhit  out  1  one-cycle data-complete pulse.
- dload  out  DATA_W  read data, valid with dhit (0 on writes).
- mem_err  out  1  one-cycle pulse on watchdog abort.

Behaviour:
- States: IDLE, DREQ, IREQ, RESP.
- Reset (nRST=0 at a rising edge):
  - state=IDLE, wait counter=0, fairness flag ifirst=0.
  - Latched address/data/write-flag registers = 0.
  - All outputs 0.
  - Reset mid-transaction abandons it; no hit or mem_err is emitted.
- IDLE arbitration, evaluated each cycle:
  - If (dREN|dWEN) and not (ifirst & iREN): go to DREQ; latch daddr, dstore, wr=dWEN.
  - Else if iREN: go to IREQ; latch iaddr; clear ifirst.
  - Else stay in IDLE.
- DREQ / IREQ outputs:
  - ramaddr = latched address.
  - ramREN = !wr; ramWEN = wr (IREQ always reads).
  - ramstore = latched store value in DREQ, else 0.
  - In every other state, ramREN=ramWEN=0 and ramaddr=ramstore=0.
- Completion in DREQ / IREQ:
  - ram_ready=1 at a clock edge: capture ram_load into a response register (0 for writes), go to RESP, reset the counter. When leaving DREQ this way, set ifirst=1.
  - Requester withdraws before ram_ready (the owning request is 0 at the edge): go to IDLE, no hit. For DREQ, owning request = dREN|dWEN.
  - Otherwise increment the counter. If counter == TIMEOUT-1 and ram_ready=0: go to RESP with the error flag set; no hit.
- Counter width is $clog2(TIMEOUT+1); it never wraps because of the abort.
- RESP:
  - Lasts exactly one cycle.
  - Outputs dhit=1 (data) or ihit=1 (instruction), with dload/iload = the captured word.
  - On abort, mem_err=1 instead, with hits 0.
  - Inputs are ignored; next state is IDLE. This prevents re-acceptance of a request the requester has not yet dropped.
- Latency:
  - Request seen in IDLE at edge 0.
  - RAM strobe visible in cycle 1.
  - ram_ready sampled at edge k (k>=1).
  - Hit high in cycle k+1.
  - Minimum request-to-hit latency is 2 cycles.
- ihit and dhit are never simultaneously 1. iload/dload are 0 outside their hit cycle.
- Fairness: after any completed data transaction, a pending iREN wins the next IDLE arbitration even if a data request is also pending.

Test Plan:
- Reset: hold nRST=0 for 2 cycles with iREN=dREN=1 → all outputs 0, no RAM strobe; after release, the first strobe is ramREN with ramaddr=daddr.
- Instruction fetch: iREN=1, iaddr=0x0000_0040, ram_ready after 3 cycles with ram_load=0x2001_0005 → ramREN=1, ramaddr=0x40 for 3 cycles; then a single ihit with iload=0x2001_0005; no second ihit while iREN stays 1 during RESP.
- Simultaneous requests: iREN=1, dWEN=1, daddr=0x100, dstore=0xDEAD_BEEF, ram_ready 1 cycle after each strobe:
  - Data served first: ramWEN, ramstore=0xDEADBEEF, dhit with dload=0.
  - Next transaction is the instruction fetch, even though dWEN is reasserted.
- Withdrawal: dREN=1, then dREN=0 two cycles later with ram_ready=0 → return to IDLE, no dhit, no mem_err, strobes drop the next cycle.
- Watchdog with TIMEOUT=4: iREN held, ram_ready=0 → ramREN high for exactly 4 cycles, then one mem_err pulse, ihit=0, then re-arbitration.
- Reset mid-transaction: nRST=0 while in DREQ → next cycle IDLE with all outputs 0; no dhit and no mem_err ever appears for that transaction.
